// File: rtl/dx_issue_stage.sv
// dx_issue_stage -- N-lane decode / operand-select stage with a registered D/X latch.
//
// Each lane decodes its opcode and resolves RS/RT against the XM and MW results of
// every lane. It then builds the ALU operands, computes the jump or recovery target
// and attaches a branch prediction. All of this is combinational; every output is
// registered on the rising clock edge, so the stage has a latency of one cycle.
//
// Build option:
//   DX_BPRED_EN  When defined, adds a BHT of BHT_DEPTH 2-bit saturating counters,
//                indexed by the low PC bits. When undefined, pred_taken is always 0
//                and the upd_* inputs are ignored.
//
// Ports:
//   clock, reset_n          rising-edge clock; asynchronous active-low reset
//   in_valid[LANES]         lane carries a valid instruction
//   instr_in, pc_in         per-lane instruction (32 b) and PC (XLEN)
//   rega_in, regb_in        per-lane register-file RS / RT values
//   xm_val, mw_val          per-lane XM / MW stage results (bypass sources)
//   fwd_rs, fwd_rt          per-lane 2*LANES hit vectors: [L-1:0] MW lane j, [2L-1:L] XM lane j
//   stall, flush            hold / squash the D/X latch (flush wins)
//   upd_valid/pc/taken      resolved-branch update to the BHT
//   out_valid, outA, outB, regb_out, jr_amt, alu_op, shamt, is_*, pred_taken
//                           registered decode results per lane
module dx_issue_stage #(
  parameter int LANES     = 2,
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [LANES-1:0]        in_valid,
  input  logic [LANES*32-1:0]     instr_in,
  input  logic [LANES*XLEN-1:0]   pc_in,
  input  logic [LANES*XLEN-1:0]   rega_in,
  input  logic [LANES*XLEN-1:0]   regb_in,
  input  logic [LANES*XLEN-1:0]   xm_val,
  input  logic [LANES*XLEN-1:0]   mw_val,
  input  logic [LANES*2*LANES-1:0] fwd_rs,
  input  logic [LANES*2*LANES-1:0] fwd_rt,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    upd_valid,
  input  logic [XLEN-1:0]         upd_pc,
  input  logic                    upd_taken,
  output logic [LANES-1:0]        out_valid,
  output logic [LANES*XLEN-1:0]   outA,
  output logic [LANES*XLEN-1:0]   outB,
  output logic [LANES*XLEN-1:0]   regb_out,
  output logic [LANES*XLEN-1:0]   jr_amt,
  output logic [LANES*5-1:0]      alu_op,
  output logic [LANES*5-1:0]      shamt,
  output logic [LANES-1:0]        is_mult,
  output logic [LANES-1:0]        is_div,
  output logic [LANES-1:0]        is_jr,
  output logic [LANES-1:0]        is_bne,
  output logic [LANES-1:0]        is_blt,
  output logic [LANES-1:0]        is_bex,
  output logic [LANES-1:0]        pred_taken
);

  localparam int HW = 2 * LANES;

  function automatic logic signed [XLEN-1:0] sextImm(input logic [16:0] imm);
    logic signed [16:0]     immS;
    logic signed [XLEN-1:0] wide;
    immS = imm;
    wide = immS;
    return wide;
  endfunction

  // Later assignments win, so the scan order MW0..MW(L-1), XM0..XM(L-1) gives the
  // highest set hit bit priority.
  function automatic logic [XLEN-1:0] pickOperand(input logic [HW-1:0] hit,
                                                  input logic [XLEN-1:0] rf);
    logic [XLEN-1:0] v;
    v = rf;
    for (int j = 0; j < LANES; j++)
      if (hit[j]) v = mw_val[XLEN*j +: XLEN];
    for (int j = 0; j < LANES; j++)
      if (hit[LANES+j]) v = xm_val[XLEN*j +: XLEN];
    return v;
  endfunction

`ifdef DX_BPRED_EN
  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [1:0]       bht [BHT_DEPTH];
  logic [IDX_W-1:0] updIdx;
  logic             unusedUpdPc;

  assign updIdx      = upd_pc[IDX_W-1:0];
  assign unusedUpdPc = ^upd_pc[XLEN-1:IDX_W];

  // Counters keep training through stall and flush; lookups read the pre-edge value.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < BHT_DEPTH; k++) bht[k] <= 2'b01;
    end else if (upd_valid) begin
      if (upd_taken) begin
        if (bht[updIdx] != 2'b11) bht[updIdx] <= bht[updIdx] + 2'b01;
      end else begin
        if (bht[updIdx] != 2'b00) bht[updIdx] <= bht[updIdx] - 2'b01;
      end
    end
  end
`else
  logic unusedUpd;
  assign unusedUpd = (^{upd_valid, upd_taken, upd_pc}) ^ (BHT_DEPTH == 0);
`endif

  for (genvar i = 0; i < LANES; i++) begin : gLane
    logic [31:0]            instr;
    logic [XLEN-1:0]        pc;
    logic [4:0]             opcode;
    logic                   isAlu, isJal, isJr, isBne, isBlt, isBex, isIType, isBranch;
    logic                   predP0;
    logic signed [XLEN-1:0] immS;
    logic [XLEN-1:0]        rsVal, rtVal;
    logic [XLEN-1:0]        opA_p0, opB_p0, regB_p0, jr_p0;
    logic [4:0]             aluOp_p0;
    logic                   unusedFields;

    logic                   vld_p1;
    logic [XLEN-1:0]        opA_p1, opB_p1, regB_p1, jr_p1;
    logic [4:0]             aluOp_p1, shamt_p1;
    logic                   mult_p1, div_p1, jr_p1f, bne_p1, blt_p1, bex_p1, pred_p1;

    assign instr        = instr_in[32*i +: 32];
    assign pc           = pc_in[XLEN*i +: XLEN];
    assign opcode       = instr[31:27];
    assign unusedFields = ^instr[26:17];

    assign isAlu    = (opcode == 5'b00000);
    assign isJal    = (opcode == 5'b00011);
    assign isJr     = (opcode == 5'b00100);
    assign isBne    = (opcode == 5'b00010);
    assign isBlt    = (opcode == 5'b00110);
    assign isBex    = (opcode == 5'b10110);
    assign isIType  = (opcode == 5'b00101) | (opcode == 5'b00111) | (opcode == 5'b01000);
    assign isBranch = isBne | isBlt;

    assign immS  = sextImm(instr[16:0]);
    assign rsVal = pickOperand(fwd_rs[HW*i +: HW], rega_in[XLEN*i +: XLEN]);
    assign rtVal = pickOperand(fwd_rt[HW*i +: HW], regb_in[XLEN*i +: XLEN]);

`ifdef DX_BPRED_EN
    logic [1:0] ctr;
    assign ctr    = bht[pc[IDX_W-1:0]];
    assign predP0 = isBranch & in_valid[i] & ctr[1];
`else
    assign predP0 = 1'b0;
`endif

    always_comb begin
      // Branches compare rt against rs, so the operands are swapped before execute.
      if (isBranch) begin
        opA_p0  = rtVal;
        regB_p0 = rsVal;
      end else begin
        opA_p0  = rsVal;
        regB_p0 = rtVal;
      end
      opB_p0 = regB_p0;
      if (isJal) begin
        opA_p0 = XLEN'(1);
        opB_p0 = pc;
      end else if (isIType) begin
        opB_p0 = $unsigned(immS);
      end else if (isBex) begin
        opB_p0 = '0;
      end
      // A predicted-taken branch carries its fall-through PC for misprediction recovery.
      if (isJr)
        jr_p0 = regB_p0;
      else if (isBranch & predP0)
        jr_p0 = pc + XLEN'(1);
      else
        jr_p0 = pc + $unsigned(immS);
      aluOp_p0 = (isIType | isJal | isBranch) ? 5'd0 : instr[6:2];
    end

    // ---- D/X latch ----
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        vld_p1   <= 1'b0;
        opA_p1   <= '0;
        opB_p1   <= '0;
        regB_p1  <= '0;
        jr_p1    <= '0;
        aluOp_p1 <= '0;
        shamt_p1 <= '0;
        mult_p1  <= 1'b0;
        div_p1   <= 1'b0;
        jr_p1f   <= 1'b0;
        bne_p1   <= 1'b0;
        blt_p1   <= 1'b0;
        bex_p1   <= 1'b0;
        pred_p1  <= 1'b0;
      end else if (flush) begin
        vld_p1 <= 1'b0;
      end else if (!stall) begin
        vld_p1   <= in_valid[i];
        opA_p1   <= opA_p0;
        opB_p1   <= opB_p0;
        regB_p1  <= regB_p0;
        jr_p1    <= jr_p0;
        aluOp_p1 <= aluOp_p0;
        shamt_p1 <= instr[11:7];
        mult_p1  <= in_valid[i] & isAlu & (instr[6:2] == 5'b00110);
        div_p1   <= in_valid[i] & isAlu & (instr[6:2] == 5'b00111);
        jr_p1f   <= in_valid[i] & isJr;
        bne_p1   <= in_valid[i] & isBne;
        blt_p1   <= in_valid[i] & isBlt;
        bex_p1   <= in_valid[i] & isBex;
        pred_p1  <= predP0;
      end
    end

    assign out_valid[i]              = vld_p1;
    assign outA[XLEN*i +: XLEN]      = opA_p1;
    assign outB[XLEN*i +: XLEN]      = opB_p1;
    assign regb_out[XLEN*i +: XLEN]  = regB_p1;
    assign jr_amt[XLEN*i +: XLEN]    = jr_p1;
    assign alu_op[5*i +: 5]          = aluOp_p1;
    assign shamt[5*i +: 5]           = shamt_p1;
    assign is_mult[i]                = mult_p1;
    assign is_div[i]                 = div_p1;
    assign is_jr[i]                  = jr_p1f;
    assign is_bne[i]                 = bne_p1;
    assign is_blt[i]                 = blt_p1;
    assign is_bex[i]                 = bex_p1;
    assign pred_taken[i]             = pred_p1;
  end

endmodule

// File: tb/tb_dx_issue_stage.sv
module tb_dx_issue_stage;
  localparam int LANES = 2;
  localparam int XLEN  = 32;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [1:0]  in_valid;
  logic [63:0] instr_in, pc_in, rega_in, regb_in, xm_val, mw_val;
  logic [7:0]  fwd_rs, fwd_rt;
  logic        stall, flush, upd_valid, upd_taken;
  logic [31:0] upd_pc;
  logic [1:0]  out_valid;
  logic [63:0] outA, outB, regb_out, jr_amt;
  logic [9:0]  alu_op, shamt;
  logic [1:0]  is_mult, is_div, is_jr, is_bne, is_blt, is_bex, pred_taken;

  logic [31:0] tIns[2], tPc[2], tRa[2], tRb[2], tXm[2], tMw[2];
  logic [3:0]  tRs[2], tRt[2];

  assign instr_in = {tIns[1], tIns[0]};
  assign pc_in    = {tPc[1], tPc[0]};
  assign rega_in  = {tRa[1], tRa[0]};
  assign regb_in  = {tRb[1], tRb[0]};
  assign xm_val   = {tXm[1], tXm[0]};
  assign mw_val   = {tMw[1], tMw[0]};
  assign fwd_rs   = {tRs[1], tRs[0]};
  assign fwd_rt   = {tRt[1], tRt[0]};

  dx_issue_stage #(.LANES(LANES), .XLEN(XLEN), .BHT_DEPTH(64)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .instr_in(instr_in),
    .pc_in(pc_in), .rega_in(rega_in), .regb_in(regb_in), .xm_val(xm_val), .mw_val(mw_val),
    .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .stall(stall), .flush(flush),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .out_valid(out_valid), .outA(outA), .outB(outB), .regb_out(regb_out), .jr_amt(jr_amt),
    .alu_op(alu_op), .shamt(shamt), .is_mult(is_mult), .is_div(is_div), .is_jr(is_jr),
    .is_bne(is_bne), .is_blt(is_blt), .is_bex(is_bex), .pred_taken(pred_taken));

  always #5 clock = ~clock;

  typedef struct {
    logic        v;
    logic [31:0] a, b, rb, jr;
    logic [4:0]  op, sh;
    logic        mul, dv, isjr, bne, blt, bex, pred;
  } lane_t;

  typedef struct {
    logic [1:0]  v;
    logic [31:0] ins0, ins1, pc0, pc1, ra0, ra1, rb0, rb1, xm0, xm1, mw0, mw1;
    logic [3:0]  rs0, rs1, rt0, rt1;
    int          lane;
    logic [1:0]  eV;
    logic [31:0] eA, eB, eRb, eJr;
    logic [4:0]  eOp;
  } vec_t;

  lane_t held[2];
  int    bhtM[64];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Newest result wins: XM before MW, higher lane before lower lane.
  function automatic logic [31:0] src(input logic [3:0] hit, input logic [31:0] rf);
    if (hit[3]) return tXm[1];
    if (hit[2]) return tXm[0];
    if (hit[1]) return tMw[1];
    if (hit[0]) return tMw[0];
    return rf;
  endfunction

  function automatic lane_t model(input int i);
    lane_t       e;
    logic [4:0]  op;
    logic [31:0] imm, rs, rt;
    logic        br, it;
    op  = tIns[i][31:27];
    imm = {{15{tIns[i][16]}}, tIns[i][16:0]};
    rs  = src(tRs[i], tRa[i]);
    rt  = src(tRt[i], tRb[i]);
    br  = (op == 5'd2) || (op == 5'd6);
    it  = (op == 5'd5) || (op == 5'd7) || (op == 5'd8);
    e.v  = in_valid[i];
    e.rb = br ? rs : rt;
    e.a  = (op == 5'd3) ? 32'd1 : (br ? rt : rs);
    if (op == 5'd3)       e.b = tPc[i];
    else if (it)          e.b = imm;
    else if (op == 5'd22) e.b = 32'd0;
    else                  e.b = e.rb;
    e.pred = 1'b0;
`ifdef DX_BPRED_EN
    e.pred = br && in_valid[i] && (bhtM[tPc[i][5:0]] >= 2);
`endif
    if (op == 5'd4)  e.jr = e.rb;
    else if (e.pred) e.jr = tPc[i] + 32'd1;
    else             e.jr = tPc[i] + imm;
    e.op   = (it || br || op == 5'd3) ? 5'd0 : tIns[i][6:2];
    e.sh   = tIns[i][11:7];
    e.mul  = in_valid[i] && op == 5'd0 && tIns[i][6:2] == 5'd6;
    e.dv   = in_valid[i] && op == 5'd0 && tIns[i][6:2] == 5'd7;
    e.isjr = in_valid[i] && op == 5'd4;
    e.bne  = in_valid[i] && op == 5'd2;
    e.blt  = in_valid[i] && op == 5'd6;
    e.bex  = in_valid[i] && op == 5'd22;
    return e;
  endfunction

  task automatic zeroModel();
    for (int i = 0; i < 2; i++) held[i] = '{default: '0};
    for (int k = 0; k < 64; k++) bhtM[k] = 1;
  endtask

  task automatic tick();
    lane_t nxt[2];
    for (int i = 0; i < 2; i++) nxt[i] = model(i);
    @(posedge clock);
    if (flush) begin
      held[0].v = 1'b0;
      held[1].v = 1'b0;
    end else if (!stall) begin
      held[0] = nxt[0];
      held[1] = nxt[1];
    end
    if (upd_valid) begin
      if (upd_taken && bhtM[upd_pc[5:0]] < 3) bhtM[upd_pc[5:0]]++;
      else if (!upd_taken && bhtM[upd_pc[5:0]] > 0) bhtM[upd_pc[5:0]]--;
    end
    #1;
  endtask

  task automatic checkAll(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s.valid%0d", tag, i), out_valid[i],          held[i].v);
      chk($sformatf("%s.outA%0d", tag, i),  outA[32*i +: 32],      held[i].a);
      chk($sformatf("%s.outB%0d", tag, i),  outB[32*i +: 32],      held[i].b);
      chk($sformatf("%s.regb%0d", tag, i),  regb_out[32*i +: 32],  held[i].rb);
      chk($sformatf("%s.jr%0d", tag, i),    jr_amt[32*i +: 32],    held[i].jr);
      chk($sformatf("%s.aluop%0d", tag, i), alu_op[5*i +: 5],      held[i].op);
      chk($sformatf("%s.shamt%0d", tag, i), shamt[5*i +: 5],       held[i].sh);
      chk($sformatf("%s.flags%0d", tag, i),
          {is_mult[i], is_div[i], is_jr[i], is_bne[i], is_blt[i], is_bex[i], pred_taken[i]},
          {held[i].mul, held[i].dv, held[i].isjr, held[i].bne, held[i].blt, held[i].bex, held[i].pred});
    end
  endtask

  task automatic randInputs();
    logic [4:0] ops[9];
    ops = '{5'd0, 5'd3, 5'd4, 5'd5, 5'd7, 5'd8, 5'd2, 5'd6, 5'd22};
    in_valid = 2'($urandom);
    for (int i = 0; i < 2; i++) begin
      tIns[i] = {ops[$urandom_range(0, 8)], 27'($urandom)};
      if (tIns[i][31:27] == 5'd0 && $urandom_range(0, 1) == 1)
        tIns[i][6:2] = 5'($urandom_range(6, 7));
      tPc[i] = $urandom & 32'hFF;
      tRa[i] = $urandom; tRb[i] = $urandom; tXm[i] = $urandom; tMw[i] = $urandom;
      tRs[i] = 4'($urandom); tRt[i] = 4'($urandom);
    end
  endtask

  task automatic setVec(input vec_t t);
    in_valid = t.v;
    tIns[0] = t.ins0; tIns[1] = t.ins1; tPc[0] = t.pc0; tPc[1] = t.pc1;
    tRa[0] = t.ra0; tRa[1] = t.ra1; tRb[0] = t.rb0; tRb[1] = t.rb1;
    tXm[0] = t.xm0; tXm[1] = t.xm1; tMw[0] = t.mw0; tMw[1] = t.mw1;
    tRs[0] = t.rs0; tRs[1] = t.rs1; tRt[0] = t.rt0; tRt[1] = t.rt1;
  endtask

  vec_t        tv[11];
  logic [63:0] savedA;

  initial begin
    //         v      ins0          ins1   pc0       pc1        ra0    ra1     rb0     rb1     xm0     xm1     mw0     mw1     rs0   rs1      rt0   rt1      ln eV     eA            eB            eRb      eJr           eOp
    tv[0]  = '{2'b01, 32'h2845FFFF, 32'h0, 32'h0,    32'h0,     32'h5, 32'h0,  32'h9,  32'h0,  32'h0,  32'h0,  32'h0,  32'h0,  4'h0, 4'h0,    4'h0, 4'h0,    0, 2'b01, 32'h5,        32'hFFFFFFFF, 32'h9,   32'hFFFFFFFF, 5'd0};
    tv[1]  = '{2'b11, 32'h0,        32'h0, 32'h0,    32'h100,   32'h1, 32'h33, 32'h2,  32'h44, 32'hAA, 32'hBB, 32'h11, 32'h22, 4'h0, 4'b0111, 4'h0, 4'h0,    1, 2'b11, 32'hAA,       32'h44,       32'h44,  32'h100,      5'd0};
    tv[2]  = '{2'b11, 32'h0,        32'h0, 32'h0,    32'h100,   32'h1, 32'h33, 32'h2,  32'h44, 32'hAA, 32'hBB, 32'h11, 32'h22, 4'h0, 4'b0001, 4'h0, 4'h0,    1, 2'b11, 32'h11,       32'h44,       32'h44,  32'h100,      5'd0};
    tv[3]  = '{2'b11, 32'h0,        32'h0, 32'h0,    32'h100,   32'h1, 32'h33, 32'h2,  32'h44, 32'hAA, 32'hBB, 32'h11, 32'h22, 4'h0, 4'b1111, 4'h0, 4'b0010, 1, 2'b11, 32'hBB,       32'h22,       32'h22,  32'h100,      5'd0};
    tv[4]  = '{2'b01, 32'h10000004, 32'h0, 32'h10,   32'h0,     32'h1, 32'h0,  32'h2,  32'h0,  32'h0,  32'h0,  32'h0,  32'h0,  4'h0, 4'h0,    4'h0, 4'h0,    0, 2'b01, 32'h2,        32'h1,        32'h1,   32'h14,       5'd0};
    tv[5]  = '{2'b01, 32'h20000000, 32'h0, 32'h10,   32'h0,     32'h3, 32'h0,  32'h40, 32'h0,  32'h0,  32'h0,  32'h0,  32'h0,  4'h0, 4'h0,    4'h0, 4'h0,    0, 2'b01, 32'h3,        32'h40,       32'h40,  32'h40,       5'd0};
    tv[6]  = '{2'b01, 32'h18000010, 32'h0, 32'h7,    32'h0,     32'h3, 32'h0,  32'h40, 32'h0,  32'h0,  32'h0,  32'h0,  32'h0,  4'h0, 4'h0,    4'h0, 4'h0,    0, 2'b01, 32'h1,        32'h7,        32'h40,  32'h17,       5'd0};
    tv[7]  = '{2'b01, 32'h0000028C, 32'h0, 32'h0,    32'h0,     32'h3, 32'h0,  32'h4,  32'h0,  32'h0,  32'h0,  32'h0,  32'h0,  4'h0, 4'h0,    4'h0, 4'h0,    0, 2'b01, 32'h3,        32'h4,        32'h4,   32'h28C,      5'd3};
    tv[8]  = '{2'b01, 32'h3001FFFC, 32'h0, 32'h20,   32'h0,     32'h7, 32'h0,  32'h8,  32'h0,  32'h0,  32'h0,  32'h0,  32'h0,  4'h0, 4'h0,    4'h0, 4'h0,    0, 2'b01, 32'h8,        32'h7,        32'h7,   32'h1C,       5'd0};
    tv[9]  = '{2'b01, 32'hB0000100, 32'h0, 32'h20,   32'h0,     32'h7, 32'h0,  32'h8,  32'h0,  32'h0,  32'h0,  32'h0,  32'h0,  4'h0, 4'h0,    4'h0, 4'h0,    0, 2'b01, 32'h7,        32'h0,        32'h8,   32'h120,      5'd0};
    tv[10] = '{2'b00, 32'h2845FFFF, 32'h0, 32'h0,    32'h0,     32'h5, 32'h0,  32'h9,  32'h0,  32'h0,  32'h0,  32'h0,  32'h0,  4'h0, 4'h0,    4'h0, 4'h0,    0, 2'b00, 32'h5,        32'hFFFFFFFF, 32'h9,   32'hFFFFFFFF, 5'd0};

    reset_n = 1'b0; stall = 1'b0; flush = 1'b0;
    upd_valid = 1'b0; upd_taken = 1'b0; upd_pc = 32'h0;
    setVec(tv[10]);
    zeroModel();
    #12;
    checkAll("reset");
    @(negedge clock);
    reset_n = 1'b1;

    // Directed vectors: hand expectations plus the full-field model.
    for (int k = 0; k < 11; k++) begin
      setVec(tv[k]);
      tick();
      chk($sformatf("vec%0d.valid", k), {30'd0, out_valid}, {30'd0, tv[k].eV});
      chk($sformatf("vec%0d.outA", k),  outA[32*tv[k].lane +: 32],     tv[k].eA);
      chk($sformatf("vec%0d.outB", k),  outB[32*tv[k].lane +: 32],     tv[k].eB);
      chk($sformatf("vec%0d.regb", k),  regb_out[32*tv[k].lane +: 32], tv[k].eRb);
      chk($sformatf("vec%0d.jr", k),    jr_amt[32*tv[k].lane +: 32],   tv[k].eJr);
      chk($sformatf("vec%0d.aluop", k), alu_op[5*tv[k].lane +: 5],     tv[k].eOp);
      checkAll($sformatf("vec%0d", k));
    end

    // Stall holds everything for three cycles while inputs change.
    setVec(tv[1]);
    tick();
    savedA = outA;
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      randInputs();
      tick();
      chk($sformatf("stall%0d.outA", c), outA[31:0], savedA[31:0]);
      chk($sformatf("stall%0d.valid", c), {30'd0, out_valid}, 32'd3);
      checkAll($sformatf("stall%0d", c));
    end
    flush = 1'b1;
    tick();
    chk("stallflush.valid", {30'd0, out_valid}, 32'd0);
    chk("stallflush.outA", outA[63:32], savedA[63:32]);
    stall = 1'b0; flush = 1'b0;

    // Randomised traffic with occasional stall, flush and BHT updates.
    for (int n = 0; n < 300; n++) begin
      randInputs();
      stall     = ($urandom_range(0, 9) == 0);
      flush     = ($urandom_range(0, 14) == 0);
      upd_valid = ($urandom_range(0, 2) == 0);
      upd_taken = 1'($urandom);
      upd_pc    = $urandom & 32'hFF;
      tick();
      checkAll($sformatf("rnd%0d", n));
    end
    stall = 1'b0; flush = 1'b0; upd_valid = 1'b0;

    // Reset asserted between edges clears outputs without a clock.
    setVec(tv[1]);
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    zeroModel();
    chk("midreset.valid", {30'd0, out_valid}, 32'd0);
    chk("midreset.outA1", outA[63:32], 32'd0);
    checkAll("midreset");
    @(negedge clock);
    reset_n = 1'b1;

`ifdef DX_BPRED_EN
    // Fresh counters predict not-taken; two taken updates make 0x10 and its alias 0x50 predict taken.
    setVec(tv[4]);
    tick();
    chk("bpred.init.pred", {31'd0, pred_taken[0]}, 32'd0);
    chk("bpred.init.jr", jr_amt[31:0], 32'h14);
    in_valid = 2'b00;
    upd_valid = 1'b1; upd_taken = 1'b1; upd_pc = 32'h10;
    tick();
    tick();
    upd_valid = 1'b0;
    setVec(tv[4]);
    tick();
    chk("bpred.pc10.pred", {31'd0, pred_taken[0]}, 32'd1);
    chk("bpred.pc10.jr", jr_amt[31:0], 32'h11);
    checkAll("bpred.pc10");
    tPc[0] = 32'h50;
    tick();
    chk("bpred.pc50.pred", {31'd0, pred_taken[0]}, 32'd1);
    chk("bpred.pc50.jr", jr_amt[31:0], 32'h51);
    checkAll("bpred.pc50");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
